// File: rtl/mem_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl_pkg
// Description : Shared encodings for the memory port controller and the
//               main multi-cycle controller: port FSM states, transaction
//               kinds and the reset value of the instruction register.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_ctrl_pkg;

  // Port FSM state encoding
  localparam logic [1:0] c_ST_IDLE = 2'b00;
  localparam logic [1:0] c_ST_BUSY = 2'b01;
  localparam logic [1:0] c_ST_ERR  = 2'b10;

  // Instruction register reset value: addi x0, x0, 0
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  // Kind of memory transaction in flight
  typedef enum logic [1:0] {
    KIND_FETCH = 2'b00,
    KIND_LOAD  = 2'b01,
    KIND_STORE = 2'b10
  } txn_kind_e;

  // A write always wins over a read; ir_write only matters for reads.
  function automatic txn_kind_e decode_kind(input logic mem_write,
                                            input logic ir_write);
    txn_kind_e kind;
    if (mem_write)     kind = KIND_STORE;
    else if (ir_write) kind = KIND_FETCH;
    else               kind = KIND_LOAD;
    return kind;
  endfunction

endpackage : mem_port_ctrl_pkg
`default_nettype wire

// File: rtl/mem_port_ctrl_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Loadable up-counter with synchronous clear and enable. The
//               terminal-count flag is raised while the count sits one below
//               TIMEOUT, i.e. when the next enabled increment reaches TIMEOUT,
//               so the owner can change state on that same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             load,
  input  logic [$clog2(TIMEOUT+1)-1:0]     load_val,
  input  logic                             en,
  output logic                             tc
);

  localparam int                CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  c_TERM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles; clear beats load beats increment, saturate at TIMEOUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != c_TERM)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tc = (r_count == c_LAST);

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl
// Description : Bridges the multi-cycle controller's memory strobes onto a
//               single registered request/ready memory port. Stalls the
//               controller while a transaction is outstanding, captures
//               fetched instructions (with their PC) and load data, and
//               latches a sticky error on bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] old_pc,
  output logic [DATA_W-1:0] mdr,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        r_state;
  txn_kind_e         r_kind;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_old_pc;
  logic [DATA_W-1:0] r_mdr;
  logic              r_err;

  logic w_req;
  logic w_idle;
  logic w_busy;
  logic w_in_err;
  logic w_accept;
  logic w_done;
  logic w_wait;
  logic w_tc;

  assign w_req    = mem_read | mem_write;
  assign w_idle   = (r_state == c_ST_IDLE);
  assign w_busy   = (r_state == c_ST_BUSY);
  assign w_in_err = (r_state == c_ST_ERR);
  assign w_accept = w_idle & w_req;
  assign w_done   = w_busy & m_ready;
  assign w_wait   = w_busy & ~m_ready;

  // Cycles spent waiting on m_ready; restarted on every accepted request
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_accept),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .en       (w_wait),
    .tc       (w_tc)
  );

  // Port FSM: accept in IDLE, hold the bus in BUSY, park forever in ERR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
      r_kind  <= KIND_FETCH;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_req) begin
            r_addr  <= adr;
            r_wdata <= wdata;
            r_we    <= mem_write;
            r_kind  <= decode_kind(mem_write, ir_write);
            r_req   <= 1'b1;
            r_state <= c_ST_BUSY;
          end
        end
        c_ST_BUSY: begin
          // Completion on the terminal cycle takes priority over timeout
          if (m_ready) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= c_ST_IDLE;
          end else if (w_tc) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_state <= c_ST_ERR;
          end
        end
        c_ST_ERR: begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
          r_err <= 1'b1;
        end
        default: begin
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Result capture: only a completing transaction updates instr/old_pc/mdr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr  <= DATA_W'(c_NOP);
      r_old_pc <= '0;
      r_mdr    <= '0;
    end else if (w_done) begin
      case (r_kind)
        KIND_FETCH: begin
          r_instr  <= m_rdata;
          r_old_pc <= pc;
        end
        KIND_LOAD: begin
          r_mdr <= m_rdata;
        end
        default: begin
          // Stores return nothing worth keeping
        end
      endcase
    end
  end

  assign stall   = w_accept | w_wait | w_in_err;
  assign instr   = r_instr;
  assign old_pc  = r_old_pc;
  assign mdr     = r_mdr;
  assign err     = r_err;
  assign m_req   = r_req;
  assign m_we    = r_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

endmodule : mem_port_ctrl
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_ctrl
// Description : Directed self-checking bench for mem_port_ctrl with a short
//               bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] adr;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] wdata;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] old_pc;
  logic [DATA_W-1:0] mdr;
  logic              err;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  int total = 0;
  int bad   = 0;

  mem_port_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .adr       (adr),
    .pc        (pc),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .stall     (stall),
    .instr     (instr),
    .old_pc    (old_pc),
    .mdr       (mdr),
    .err       (err),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; adr = '0; pc = '0; wdata = '0;
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
    m_rdata = '0; m_ready = 1'b0;

    // ---------------- reset ----------------
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("rst_instr",  instr,  64'h13);
    chk("rst_mdr",    mdr,    64'h0);
    chk("rst_oldpc",  old_pc, 64'h0);
    chk("rst_mreq",   m_req,  64'h0);
    chk("rst_mwe",    m_we,   64'h0);
    chk("rst_maddr",  m_addr, 64'h0);
    chk("rst_stall",  stall,  64'h0);
    chk("rst_err",    err,    64'h0);

    // ---------------- fetch, zero wait ----------------
    step();
    pc = 32'h40; adr = 32'h40; mem_read = 1'b1; ir_write = 1'b1;
    #1;
    chk("f_acc_stall", stall, 64'h1);
    chk("f_acc_mreq",  m_req, 64'h0);
    step();
    m_ready = 1'b1; m_rdata = 32'h0050_0093;
    #1;
    chk("f_busy_mreq",  m_req,  64'h1);
    chk("f_busy_maddr", m_addr, 64'h40);
    chk("f_busy_mwe",   m_we,   64'h0);
    chk("f_busy_stall", stall,  64'h0);
    step();
    mem_read = 1'b0; ir_write = 1'b0; m_ready = 1'b0; m_rdata = '0;
    #1;
    chk("f_instr",     instr,  64'h0050_0093);
    chk("f_oldpc",     old_pc, 64'h40);
    chk("f_done_mreq", m_req,  64'h0);
    chk("f_done_stall", stall, 64'h0);
    chk("f_mdr",       mdr,    64'h0);

    // ---------------- load, 3 wait states ----------------
    step();
    pc = 32'h44; adr = 32'h100; mem_read = 1'b1;
    #1;
    chk("l_acc_stall", stall, 64'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      adr = 32'h999; m_rdata = 32'hBAD0_0000 | 32'(i);
      #1;
      chk("l_wait_stall", stall,  64'h1);
      chk("l_wait_maddr", m_addr, 64'h100);
      chk("l_wait_mreq",  m_req,  64'h1);
    end
    step();
    m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("l_rdy_stall", stall,  64'h0);
    chk("l_rdy_maddr", m_addr, 64'h100);
    step();
    mem_read = 1'b0; m_ready = 1'b0; m_rdata = '0;
    #1;
    chk("l_mdr",    mdr,    64'hDEAD_BEEF);
    chk("l_instr",  instr,  64'h0050_0093);
    chk("l_oldpc",  old_pc, 64'h40);
    chk("l_mreq",   m_req,  64'h0);

    // ---------------- store ----------------
    step();
    adr = 32'h200; wdata = 32'h1234; mem_write = 1'b1;
    #1;
    chk("s_acc_stall", stall, 64'h1);
    step();
    m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("s_mwe",    m_we,    64'h1);
    chk("s_mwdata", m_wdata, 64'h1234);
    chk("s_maddr",  m_addr,  64'h200);
    step();
    mem_write = 1'b0; m_ready = 1'b0;
    #1;
    chk("s_mdr",    mdr,   64'hDEAD_BEEF);
    chk("s_instr",  instr, 64'h0050_0093);
    chk("s_mwe_lo", m_we,  64'h0);

    // ---------------- read and write together: store wins ----------------
    step();
    adr = 32'h204; wdata = 32'h5678; mem_read = 1'b1; mem_write = 1'b1; ir_write = 1'b1;
    step();
    m_ready = 1'b1; m_rdata = 32'h1111_1111;
    #1;
    chk("rw_mwe",    m_we,    64'h1);
    chk("rw_mwdata", m_wdata, 64'h5678);
    step();
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; m_ready = 1'b0;
    #1;
    chk("rw_instr", instr, 64'h0050_0093);
    chk("rw_mdr",   mdr,   64'hDEAD_BEEF);

    // ---------------- stray m_ready in IDLE ----------------
    step();
    m_ready = 1'b1; m_rdata = 32'h2222_2222;
    step();
    m_ready = 1'b0;
    #1;
    chk("idle_rdy_mdr",   mdr,   64'hDEAD_BEEF);
    chk("idle_rdy_instr", instr, 64'h0050_0093);
    chk("idle_rdy_mreq",  m_req, 64'h0);

    // ---------------- m_ready on the exact timeout cycle ----------------
    step();
    adr = 32'h300; mem_read = 1'b1;
    repeat (3) step();
    step();
    m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
    #1;
    chk("tb_last_stall", stall, 64'h0);
    step();
    mem_read = 1'b0; m_ready = 1'b0;
    #1;
    chk("tb_err", err, 64'h0);
    chk("tb_mdr", mdr, 64'hCAFE_F00D);

    // ---------------- timeout ----------------
    step();
    adr = 32'h304; mem_read = 1'b1;
    repeat (3) step();
    step();
    #1;
    chk("to_pre_err",  err,   64'h0);
    chk("to_pre_mreq", m_req, 64'h1);
    step();
    #1;
    chk("to_err",   err,   64'h1);
    chk("to_mreq",  m_req, 64'h0);
    chk("to_stall", stall, 64'h1);
    step();
    mem_read = 1'b0; m_ready = 1'b1; m_rdata = 32'h3333_3333;
    repeat (2) step();
    m_ready = 1'b0;
    #1;
    chk("to_late_err",   err,   64'h1);
    chk("to_late_stall", stall, 64'h1);
    chk("to_late_mdr",   mdr,   64'hCAFE_F00D);
    #1;
    rst = 1'b0;
    #1;
    chk("to_rst_err",   err,   64'h0);
    chk("to_rst_stall", stall, 64'h0);
    #1;
    rst = 1'b1;

    // ---------------- reset while BUSY ----------------
    step();
    adr = 32'h400; mem_read = 1'b1;
    step();
    #1;
    chk("rb_mreq_hi", m_req, 64'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("rb_mreq_lo", m_req, 64'h0);
    mem_read = 1'b0;
    #1;
    rst = 1'b1;
    step();
    m_ready = 1'b1; m_rdata = 32'h4444_4444;
    step();
    m_ready = 1'b0;
    #1;
    chk("rb_mdr",   mdr,   64'h0);
    chk("rb_instr", instr, 64'h13);
    chk("rb_mreq",  m_req, 64'h0);
    chk("rb_stall", stall, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_ctrl
`default_nettype wire
